// File: rtl/fast_cmd_pkg.sv
// Shared fast-command word/code definitions used by the encoder side and the
// receiver-side decoder so both ends agree on one table.
package fast_cmd_pkg;

  localparam logic [7:0] WORD_IDLE       = 8'hF0;
  localparam logic [7:0] WORD_LINK_RESET = 8'h33;
  localparam logic [7:0] WORD_BCR        = 8'h5A;
  localparam logic [7:0] WORD_STP        = 8'h55;
  localparam logic [7:0] WORD_L1ACR      = 8'h66;
  localparam logic [7:0] WORD_CHARGE_INJ = 8'h69;
  localparam logic [7:0] WORD_L1A        = 8'h96;
  localparam logic [7:0] WORD_L1A_BCR    = 8'h99;
  localparam logic [7:0] WORD_WS_START   = 8'hA5;
  localparam logic [7:0] WORD_WS_STOP    = 8'hAA;

  localparam logic [3:0] FC_IDLE       = 4'd0;
  localparam logic [3:0] FC_LINK_RESET = 4'd1;
  localparam logic [3:0] FC_BCR        = 4'd2;
  localparam logic [3:0] FC_STP        = 4'd3;
  localparam logic [3:0] FC_L1ACR      = 4'd4;
  localparam logic [3:0] FC_CHARGE_INJ = 4'd5;
  localparam logic [3:0] FC_L1A        = 4'd6;
  localparam logic [3:0] FC_L1A_BCR    = 4'd7;
  localparam logic [3:0] FC_WS_START   = 4'd8;
  localparam logic [3:0] FC_WS_STOP    = 4'd9;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_CHECK,
    ST_LOCKED
  } align_state_e;

  // Returns {legal, code}; illegal words report code 0.
  function automatic logic [4:0] fc_decode(input logic [7:0] word);
    case (word)
      WORD_IDLE:       return {1'b1, FC_IDLE};
      WORD_LINK_RESET: return {1'b1, FC_LINK_RESET};
      WORD_BCR:        return {1'b1, FC_BCR};
      WORD_STP:        return {1'b1, FC_STP};
      WORD_L1ACR:      return {1'b1, FC_L1ACR};
      WORD_CHARGE_INJ: return {1'b1, FC_CHARGE_INJ};
      WORD_L1A:        return {1'b1, FC_L1A};
      WORD_L1A_BCR:    return {1'b1, FC_L1A_BCR};
      WORD_WS_START:   return {1'b1, FC_WS_START};
      WORD_WS_STOP:    return {1'b1, FC_WS_STOP};
      default:         return {1'b0, FC_IDLE};
    endcase
  endfunction

endpackage

// File: rtl/fast_cmd_word_decode.sv
// Combinational map from one aligned 8-bit fast-command word to its code.
module fast_cmd_word_decode
  import fast_cmd_pkg::*;
(
  input  logic [7:0] word,
  output logic       legal,
  output logic [3:0] code
);

  assign {legal, code} = fc_decode(word);

endmodule

// File: rtl/fast_command_decoder.sv
// Fast-command receiver: hunts for idle-word byte alignment on the serial
// line, then decodes each aligned word and tracks illegal words.
module fast_command_decoder
  import fast_cmd_pkg::*;
#(
  parameter int unsigned LOCK_COUNT   = 8,
  parameter int unsigned UNLOCK_COUNT = 4
) (
  input  logic        clk320,
  input  logic        rstn,
  input  logic        sin,
  input  logic        clear_err,
  output logic        locked,
  output logic        cmd_valid,
  output logic [3:0]  cmd_code,
  output logic        l1a_pulse,
  output logic        cmd_err,
  output logic [15:0] err_count
);

  localparam logic [7:0] LOCK_TARGET   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_TARGET = 8'(UNLOCK_COUNT);

  align_state_e state, state_nxt;
  logic [7:0]   shreg, nxt;
  logic [2:0]   bit_cnt, bit_cnt_nxt;
  logic [7:0]   good_cnt, good_nxt, bad_cnt, bad_nxt;
  logic         word_legal, boundary;
  logic [3:0]   word_code, code_nxt;
  logic         valid_nxt, l1a_nxt, err_nxt;

  assign nxt      = {shreg[6:0], sin};
  assign boundary = (bit_cnt == 3'd7);
  assign locked   = (state == ST_LOCKED);

  fast_cmd_word_decode u_word_decode (
    .word  (nxt),
    .legal (word_legal),
    .code  (word_code)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt + 3'd1;
    good_nxt    = good_cnt;
    bad_nxt     = bad_cnt;
    code_nxt    = cmd_code;
    valid_nxt   = 1'b0;
    l1a_nxt     = 1'b0;
    err_nxt     = 1'b0;
    unique case (state)
      ST_SEARCH: begin
        // Rotations of F0 never equal F0, so the first hit fixes the phase.
        if (nxt == WORD_IDLE) begin
          bit_cnt_nxt = 3'd0;
          good_nxt    = 8'd1;
          state_nxt   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (boundary) begin
          if (!word_legal) begin
            good_nxt  = 8'd0;
            state_nxt = ST_SEARCH;
          end else if (word_code == FC_IDLE) begin
            good_nxt = good_cnt + 8'd1;
            if (good_nxt == LOCK_TARGET) begin
              // The idle that completes lock is already reported as a command.
              state_nxt = ST_LOCKED;
              valid_nxt = 1'b1;
              code_nxt  = FC_IDLE;
            end
          end
        end
      end
      ST_LOCKED: begin
        if (boundary) begin
          if (word_legal) begin
            valid_nxt = 1'b1;
            code_nxt  = word_code;
            bad_nxt   = 8'd0;
            l1a_nxt   = (word_code == FC_L1A) || (word_code == FC_L1A_BCR);
          end else begin
            err_nxt = 1'b1;
            bad_nxt = bad_cnt + 8'd1;
            if (bad_nxt == UNLOCK_TARGET) begin
              bad_nxt   = 8'd0;
              good_nxt  = 8'd0;
              state_nxt = ST_SEARCH;
            end
          end
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk320 or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_SEARCH;
      shreg     <= '0;
      bit_cnt   <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= FC_IDLE;
      l1a_pulse <= 1'b0;
      cmd_err   <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      shreg     <= nxt;
      bit_cnt   <= bit_cnt_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
      cmd_valid <= valid_nxt;
      cmd_code  <= code_nxt;
      l1a_pulse <= l1a_nxt;
      cmd_err   <= err_nxt;
      // Clearing wins over a same-edge increment.
      if (clear_err)
        err_count <= '0;
      else if (err_nxt && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: doc/fast_command_decoder.md
Name: fast_command_decoder

Overview:
Downstream consumer of the fast-command serial stream that the fast-command memory controller produces on the test board. It recovers byte alignment on the 320 MHz serial line (MSB first, one 8-bit word per 40 MHz frame) by hunting for the idle word 0xF0. It decodes each aligned word back to the 4-bit fast-command code and flags illegal words. It serves as the loop-back checker and as the on-board emulation of the ETROC fast-command receiver.

Parameters:
LOCK_COUNT, 8, consecutive frame-aligned idle words needed to declare lock (range 2..255)
UNLOCK_COUNT, 4, consecutive illegal words in LOCKED that force re-search (range 1..255)

Ports:
clk320 input 1 serial bit clock; one bit sampled per rising edge
rstn input 1 asynchronous active-low reset
sin input 1 serial fast-command stream, MSB first, already synchronous to clk320
clear_err input 1 synchronous, level: zeroes err_count while high
locked output 1 high while in LOCKED
cmd_valid output 1 one-cycle pulse per legal word decoded in LOCKED, idle included
cmd_code output 4 decoded code, held between pulses (0 idle, 1 linkReset, 2 BCR, 3 STP, 4 L1ACR, 5 chargeInj, 6 L1A, 7 L1A_BCR, 8 WS_start, 9 WS_stop)
l1a_pulse output 1 one-cycle pulse when the decoded code is 6 or 7
cmd_err output 1 one-cycle pulse per illegal word in LOCKED
err_count output 16 saturating count of illegal words seen in LOCKED

Behaviour:
- Shift register each edge: shreg <= {shreg[6:0], sin}. Candidate word nxt = {shreg[6:0], sin}.
- bit_cnt is 3 bits and wraps 7->0. A boundary edge is an edge with bit_cnt==7. nxt is the complete word at a boundary edge.
- Word map: F0->0, 33->1, 5A->2, 55->3, 66->4, 69->5, 96->6, 99->7, A5->8, AA->9. Every other byte is illegal.
- Reset: shreg=0, bit_cnt=0, state SEARCH, locked=0, cmd_valid=0, cmd_code=0, l1a_pulse=0, cmd_err=0, err_count=0, good_cnt=0, bad_cnt=0. Reset mid-operation drops lock immediately, asynchronously.
- FSM states SEARCH, CHECK, LOCKED:
  - SEARCH:
    - Every edge, if nxt==F0: set bit_cnt<=0 so the next 8 edges form one frame, set good_cnt<=1, go to CHECK. bit_cnt is ignored while in SEARCH.
    - A rotated idle (E1, C3, 87, 0F, 1E, 3C, 78) never matches, so the first match fixes the phase uniquely.
  - CHECK, at boundary edges only:
    - nxt==F0: good_cnt++. When the incremented value equals LOCK_COUNT, go to LOCKED.
    - Other legal word: good_cnt held.
    - Illegal word: go to SEARCH, good_cnt=0.
  - LOCKED, at boundary edges only:
    - Legal word: cmd_valid=1, cmd_code=code, bad_cnt=0; l1a_pulse=1 if code is 6 or 7.
    - Illegal word: cmd_err=1, err_count++ (saturates at 0xFFFF), bad_cnt++. cmd_code keeps its previous value.
    - When bad_cnt reaches UNLOCK_COUNT: go to SEARCH, locked=0 on the next edge, bad_cnt=0.
- Latency: outputs are registered on the boundary edge that samples the word's last bit (LSB). cmd_valid, l1a_pulse and cmd_err are high for exactly the following clk320 cycle, then low for 7 cycles.
- locked rises in the cycle after the LOCK_COUNT-th idle's boundary edge. That boundary word's decode is already emitted, so the first cmd_valid coincides with locked rising.
- No outputs pulse in SEARCH or CHECK.
- clear_err has priority over an increment on the same edge: the count is 0, not 1.
- A long run of 0 or 1 bits never matches F0, so the block stays in SEARCH.

Decomposition:
- Shared package fast_cmd_pkg holds:
  - the 8-bit word localparams (idle, linkReset, BCR, STP, L1ACR, chargeInj, L1A, L1A_BCR, WS_start, WS_stop);
  - the 4-bit fc_* code localparams;
  - a word-to-code decode function returning {legal, code}.
- The encoder in the command memory controller is rewritten to use the same package.
- One sub-module is natural: fast_cmd_word_decode, purely combinational (8-bit word in; legal and 4-bit code out), instantiated once.
- Alignment FSM, counters and output registers stay in the top module.

Test Plan:
1. Idle stream F0 repeated, starting at a random bit phase (0..7) after reset -> locked rises after exactly LOCK_COUNT=8 aligned idles. cmd_valid then pulses every 8 cycles with cmd_code=0; cmd_err never asserts.
2. Locked, send 96, 99, 5A, A5, AA -> cmd_code 6, 7, 2, 8, 9 in order. l1a_pulse high only for the first two words. Each pulse is 1 cycle after the LSB-sampling edge.
3. Locked, inject 3 illegal words (e.g. F1), then 33 -> cmd_err pulses 3 times, err_count=3, locked stays 1, and cmd_code=1 after the 33. Then 4 consecutive illegal words -> locked falls after the 4th, err_count=7.
4. Locked, slip the stream by 1 bit (drop one bit) -> words decode illegal, UNLOCK_COUNT errors drop lock, and the decoder relocks at the new phase after 8 aligned idles.
5. In CHECK after 5 idles, one illegal word -> return to SEARCH; lock needs a fresh 8 idles (no partial credit).
6. err_count preloaded to 0xFFFE by 3 errors past it -> count saturates at 0xFFFF. Assert clear_err on an error edge -> err_count=0. Deassert rstn mid-frame -> all outputs 0 immediately.
